mem_stage: RTL and testbench

- MEM pipeline stage of the LoongArch five-stage CPU, between EX and WB.
- Registers the EX payload and waits for the data-SRAM response of an already-issued load or store.
- Aligns and sign- or zero-extends load data, then emits the 103-bit MEM_to_WB_zip and the 82-bit MEM_except_zip consumed by WB.
- Provides bypass/block information to ID.
- Absorbs an orphaned SRAM response after a pipeline flush.

---
 rtl/mem_stage.sv | 213 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage of the five-stage LoongArch pipeline: holds the EX payload, waits for the
// data-SRAM response, aligns load data and feeds WB, the ID bypass network and flush recovery.
module mem_stage #(
    parameter int ZIP_EX_W = 110,
    parameter int EXC_W    = 82
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ZIP_EX_W-1:0] EX_to_MEM_zip,
    input  logic [EXC_W-1:0]    EX_except_zip,
    input  logic                WB_allowin,
    input  logic                wb_flush,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    output logic                MEM_allowin,
    output logic [102:0]        MEM_to_WB_zip,
    output logic [EXC_W-1:0]    MEM_except_zip,
    output logic [38:0]         MEM_fwd_zip
);

    // csr_re sits in the top bit of the exception/CSR bundle
    localparam int CSR_RE_BIT = EXC_W - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // Unpacked EX payload
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_ir;
    logic        ex_gr_we;
    logic [4:0]  ex_rf_waddr;
    logic [31:0] ex_alu_result;
    logic        ex_res_from_mem;
    logic        ex_mem_req;
    logic [4:0]  ex_load_op;

    assign {ex_valid, ex_pc, ex_ir, ex_gr_we, ex_rf_waddr, ex_alu_result,
            ex_res_from_mem, ex_mem_req, ex_load_op} = EX_to_MEM_zip;

    // Registered state
    state_t             state_reg;
    state_t             state_next;
    logic               valid_reg;
    logic               valid_next;
    logic [31:0]        pc_reg;
    logic [31:0]        ir_reg;
    logic               gr_we_reg;
    logic [4:0]         rf_waddr_reg;
    logic [31:0]        alu_result_reg;
    logic               res_from_mem_reg;
    logic               mem_req_reg;
    logic [4:0]         load_op_reg;
    logic [EXC_W-1:0]   except_reg;
    logic [31:0]        buf_reg;

    // Handshake
    logic ready_go;
    logic accept;
    logic buf_we;

    assign ready_go    = !mem_req_reg || data_sram_data_ok || (state_reg == S_HOLD);
    assign MEM_allowin = (state_reg != S_DRAIN) && (!valid_reg || (ready_go && WB_allowin));
    assign accept      = MEM_allowin && ex_valid && !wb_flush;

    // Next-state logic; a flush overrides every other transition
    always_comb begin
        state_next = state_reg;
        valid_next = valid_reg;
        buf_we     = 1'b0;
        if (wb_flush) begin
            valid_next = 1'b0;
            case (state_reg)
                S_WAIT:  state_next = data_sram_data_ok ? S_IDLE : S_DRAIN;
                S_HOLD:  state_next = S_IDLE;
                S_DRAIN: state_next = data_sram_data_ok ? S_IDLE : S_DRAIN;
                default: state_next = S_IDLE;
            endcase
        end else begin
            if (MEM_allowin) begin
                valid_next = ex_valid;
            end
            case (state_reg)
                S_IDLE: begin
                    if (accept && ex_mem_req) begin
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (data_sram_data_ok) begin
                        if (WB_allowin) begin
                            state_next = (accept && ex_mem_req) ? S_WAIT : S_IDLE;
                        end else begin
                            state_next = S_HOLD;
                            buf_we     = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (WB_allowin) begin
                        state_next = (accept && ex_mem_req) ? S_WAIT : S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (data_sram_data_ok) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg           <= '0;
            ir_reg           <= '0;
            gr_we_reg        <= 1'b0;
            rf_waddr_reg     <= '0;
            alu_result_reg   <= '0;
            res_from_mem_reg <= 1'b0;
            mem_req_reg      <= 1'b0;
            load_op_reg      <= '0;
            except_reg       <= '0;
        end else if (accept) begin
            pc_reg           <= ex_pc;
            ir_reg           <= ex_ir;
            gr_we_reg        <= ex_gr_we;
            rf_waddr_reg     <= ex_rf_waddr;
            alu_result_reg   <= ex_alu_result;
            res_from_mem_reg <= ex_res_from_mem;
            mem_req_reg      <= ex_mem_req;
            load_op_reg      <= ex_load_op;
            except_reg       <= EX_except_zip;
        end
    end

    // Response buffer: keeps the word while WB is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_reg <= '0;
        end else if (buf_we) begin
            buf_reg <= data_sram_rdata;
        end
    end

    // Load alignment
    logic [31:0] load_src;
    logic [7:0]  lane [4];
    logic [1:0]  off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;

    assign load_src = (state_reg == S_HOLD) ? buf_reg : data_sram_rdata;
    assign off      = alu_result_reg[1:0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = load_src[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[off];
    assign half_sel = off[1] ? load_src[31:16] : load_src[15:0];

    // load_op is one-hot {b, h, w, bu, hu}
    always_comb begin
        load_data = load_src;
        if (load_op_reg[4]) begin
            load_data = {{24{byte_sel[7]}}, byte_sel};
        end else if (load_op_reg[3]) begin
            load_data = {{16{half_sel[15]}}, half_sel};
        end else if (load_op_reg[2]) begin
            load_data = load_src;
        end else if (load_op_reg[1]) begin
            load_data = {24'd0, byte_sel};
        end else if (load_op_reg[0]) begin
            load_data = {16'd0, half_sel};
        end
    end

    assign rf_wdata = res_from_mem_reg ? load_data : alu_result_reg;

    // Outputs
    logic wb_valid;
    logic fwd_we;
    logic fwd_block;

    assign wb_valid  = valid_reg && ready_go && !wb_flush;
    assign fwd_we    = valid_reg && gr_we_reg;
    assign fwd_block = valid_reg && ((res_from_mem_reg && !ready_go) || except_reg[CSR_RE_BIT]);

    assign MEM_to_WB_zip  = {wb_valid, pc_reg, ir_reg, gr_we_reg, rf_waddr_reg, rf_wdata};
    assign MEM_except_zip = except_reg;
    assign MEM_fwd_zip    = {fwd_we, rf_waddr_reg, rf_wdata, fwd_block};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand-written stall/flush/reset sequences,
// then randomized traffic compared against a transaction-level model of the stage.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [109:0] ex_zip;
    logic [81:0]  ex_exc;
    logic         wb_allowin;
    logic         wb_flush;
    logic         data_ok;
    logic [31:0]  rdata;
    logic         mem_allowin;
    logic [102:0] wb_zip;
    logic [81:0]  mem_exc;
    logic [38:0]  fwd_zip;

    int errors = 0;
    int checks = 0;

    localparam logic [4:0] LB  = 5'b10000;
    localparam logic [4:0] LH  = 5'b01000;
    localparam logic [4:0] LW  = 5'b00100;
    localparam logic [4:0] LBU = 5'b00010;
    localparam logic [4:0] LHU = 5'b00001;

    mem_stage #(.ZIP_EX_W(110), .EXC_W(82)) dut (
        .clk               (clk),
        .rst               (rst),
        .EX_to_MEM_zip     (ex_zip),
        .EX_except_zip     (ex_exc),
        .WB_allowin        (wb_allowin),
        .wb_flush          (wb_flush),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata),
        .MEM_allowin       (mem_allowin),
        .MEM_to_WB_zip     (wb_zip),
        .MEM_except_zip    (mem_exc),
        .MEM_fwd_zip       (fwd_zip)
    );

    always #5 clk = ~clk;

    function automatic logic [109:0] mk_ex(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                                           input logic we, input logic [4:0] wa, input logic [31:0] alu,
                                           input logic rfm, input logic mreq, input logic [4:0] lop);
        return {v, pc, ir, we, wa, alu, rfm, mreq, lop};
    endfunction

    // Reference load extraction from the architectural rules
    function automatic logic [31:0] ref_load(input logic [4:0] lop, input logic [1:0] o, input logic [31:0] w);
        logic [31:0] sb;
        logic [31:0] sh;
        sb = w >> (8 * o);
        sh = w >> (16 * o[1]);
        case (lop)
            LB:      return 32'(int'(byte'(sb)));
            LH:      return 32'(int'(shortint'(sh)));
            LBU:     return sb & 32'h0000_00FF;
            LHU:     return sh & 32'h0000_FFFF;
            default: return w;
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_zip     = '0;
        ex_exc     = '0;
        wb_allowin = 1'b1;
        wb_flush   = 1'b0;
        data_ok    = 1'b0;
        rdata      = '0;
    endtask

    typedef struct {
        logic [4:0]  lop;
        logic        rfm;
        logic        mreq;
        logic        we;
        logic [31:0] alu;
        logic [31:0] rd;
        int          dly;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input int i);
        logic [31:0] pc;
        logic [31:0] ir;
        pc = 32'h1c00_0000 + 32'(i * 4);
        ir = 32'h0280_0000 | 32'(i);
        ex_zip = mk_ex(1'b1, pc, ir, vecs[i].we, 5'd5, vecs[i].alu, vecs[i].rfm, vecs[i].mreq, vecs[i].lop);
        #1;
        chk("accept_allowin", mem_allowin, 1'b1);
        tick();
        ex_zip = '0;
        for (int d = 0; d < vecs[i].dly; d++) begin
            #1;
            chk("wait_allowin", mem_allowin, 1'b0);
            chk("wait_block", fwd_zip[0], vecs[i].rfm);
            chk("wait_valid", wb_zip[102], 1'b0);
            tick();
        end
        data_ok = vecs[i].mreq;
        rdata   = vecs[i].rd;
        #1;
        chk("vec_wb_zip", wb_zip, {1'b1, pc, ir, vecs[i].we, 5'd5, vecs[i].exp});
        chk("vec_fwd_zip", fwd_zip, {vecs[i].we, 5'd5, vecs[i].exp, 1'b0});
        chk("vec_allowin", mem_allowin, 1'b1);
        $display("vec %0d: lop=%b alu=%h rdata=%h wdata=%h", i, vecs[i].lop, vecs[i].alu, vecs[i].rd, wb_zip[31:0]);
        tick();
        data_ok = 1'b0;
        #1;
        chk("vec_drop_valid", wb_zip[102], 1'b0);
    endtask

    // Transaction-level model state
    logic        m_valid, m_got, m_orphan;
    logic [31:0] m_pc, m_ir, m_alu, m_buf;
    logic        m_we, m_rfm, m_mreq;
    logic [4:0]  m_wa, m_lop;
    logic [81:0] m_exc;

    logic        done, e_allow;
    logic [31:0] e_wd;
    logic [81:0] r_exc;
    logic [4:0]  r_lop;

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_allowin", mem_allowin, 1'b1);
        chk("rst_wb_zip", wb_zip, '0);
        chk("rst_exc", mem_exc, '0);
        chk("rst_fwd", fwd_zip, '0);
        rst = 1'b0;
        tick();

        vecs[0] = '{lop: 5'd0, rfm: 1'b0, mreq: 1'b0, we: 1'b1, alu: 32'h1234_5678, rd: 32'h0, dly: 0, exp: 32'h1234_5678};
        vecs[1] = '{lop: LB,  rfm: 1'b1, mreq: 1'b1, we: 1'b1, alu: 32'h0000_1003, rd: 32'h80AA_BBCC, dly: 2, exp: 32'hFFFF_FF80};
        vecs[2] = '{lop: LBU, rfm: 1'b1, mreq: 1'b1, we: 1'b1, alu: 32'h0000_1003, rd: 32'h80AA_BBCC, dly: 2, exp: 32'h0000_0080};
        vecs[3] = '{lop: LH,  rfm: 1'b1, mreq: 1'b1, we: 1'b1, alu: 32'h0000_2002, rd: 32'h7FFE_0001, dly: 1, exp: 32'h0000_7FFE};
        vecs[4] = '{lop: LHU, rfm: 1'b1, mreq: 1'b1, we: 1'b1, alu: 32'h0000_2000, rd: 32'h0000_ABCD, dly: 1, exp: 32'h0000_ABCD};
        vecs[5] = '{lop: LW,  rfm: 1'b1, mreq: 1'b1, we: 1'b1, alu: 32'h0000_3000, rd: 32'hDEAD_BEEF, dly: 0, exp: 32'hDEAD_BEEF};
        vecs[6] = '{lop: 5'd0, rfm: 1'b0, mreq: 1'b1, we: 1'b0, alu: 32'h55AA_0004, rd: 32'h9999_9999, dly: 1, exp: 32'h55AA_0004};
        vecs[7] = '{lop: LB,  rfm: 1'b1, mreq: 1'b1, we: 1'b1, alu: 32'h0000_4001, rd: 32'h0000_7F00, dly: 0, exp: 32'h0000_007F};
        vecs[8] = '{lop: LH,  rfm: 1'b1, mreq: 1'b1, we: 1'b1, alu: 32'h0000_4000, rd: 32'h0000_8001, dly: 3, exp: 32'hFFFF_8001};
        for (int i = 0; i < 9; i++) run_vec(i);

        // WB stalls while the response arrives: the word must be buffered
        ex_zip = mk_ex(1'b1, 32'h1c00_0100, 32'h2880_0000, 1'b1, 5'd9, 32'h0000_5000, 1'b1, 1'b1, LW);
        ex_exc = 82'h2_1234_5678_9ABC_DEF0_1357;
        tick();
        ex_zip = '0;
        ex_exc = '0;
        wb_allowin = 1'b0;
        data_ok    = 1'b1;
        rdata      = 32'hDEAD_BEEF;
        #1;
        chk("hold_entry_valid", wb_zip[102], 1'b1);
        chk("hold_entry_allowin", mem_allowin, 1'b0);
        chk("hold_exc", mem_exc, 82'h2_1234_5678_9ABC_DEF0_1357);
        tick();
        for (int k = 0; k < 3; k++) begin
            data_ok = (k % 2 == 0);
            rdata   = $urandom;
            #1;
            chk("hold_data", wb_zip[31:0], 32'hDEAD_BEEF);
            chk("hold_allowin", mem_allowin, 1'b0);
            chk("hold_block", fwd_zip[0], 1'b1);
            tick();
        end
        wb_allowin = 1'b1;
        data_ok    = 1'b0;
        #1;
        chk("hold_release_data", wb_zip, {1'b1, 32'h1c00_0100, 32'h2880_0000, 1'b1, 5'd9, 32'hDEAD_BEEF});
        chk("hold_release_allowin", mem_allowin, 1'b1);
        $display("hold sequence: wdata=%h", wb_zip[31:0]);
        tick();
        #1;
        chk("hold_done_valid", wb_zip[102], 1'b0);

        // Flush while waiting: orphan response must be drained
        ex_zip = mk_ex(1'b1, 32'h1c00_0200, 32'h2880_0001, 1'b1, 5'd3, 32'h0000_6000, 1'b1, 1'b1, LW);
        tick();
        wb_flush = 1'b1;
        ex_zip   = mk_ex(1'b1, 32'h1c00_0204, 32'h0, 1'b1, 5'd4, 32'hCAFE_0001, 1'b0, 1'b0, 5'd0);
        #1;
        chk("flush_valid", wb_zip[102], 1'b0);
        tick();
        wb_flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("drain_allowin", mem_allowin, 1'b0);
            chk("drain_valid", wb_zip[102], 1'b0);
            tick();
        end
        data_ok = 1'b1;
        rdata   = 32'h0BAD_0BAD;
        #1;
        chk("drain_ok_allowin", mem_allowin, 1'b0);
        chk("drain_ok_valid", wb_zip[102], 1'b0);
        tick();
        data_ok = 1'b0;
        #1;
        chk("drain_exit_allowin", mem_allowin, 1'b1);
        chk("drain_exit_valid", wb_zip[102], 1'b0);
        tick();
        ex_zip = '0;
        #1;
        chk("after_drain_accept", wb_zip, {1'b1, 32'h1c00_0204, 32'h0, 1'b1, 5'd4, 32'hCAFE_0001});
        $display("drain sequence: post-drain wdata=%h", wb_zip[31:0]);
        tick();

        // Flush coincident with the response: straight to IDLE
        ex_zip = mk_ex(1'b1, 32'h1c00_0300, 32'h2880_0002, 1'b1, 5'd6, 32'h0000_7000, 1'b1, 1'b1, LW);
        tick();
        ex_zip   = '0;
        wb_flush = 1'b1;
        data_ok  = 1'b1;
        #1;
        chk("flush_ok_valid", wb_zip[102], 1'b0);
        tick();
        wb_flush = 1'b0;
        data_ok  = 1'b0;
        #1;
        chk("flush_ok_idle", mem_allowin, 1'b1);
        $display("flush+data_ok sequence: allowin=%b", mem_allowin);
        tick();

        // Asynchronous reset in the middle of a wait
        ex_zip = mk_ex(1'b1, 32'h1c00_0400, 32'h2800_0003, 1'b1, 5'd7, 32'h0000_8001, 1'b1, 1'b1, LB);
        tick();
        ex_zip = '0;
        #1;
        chk("pre_rst_fwd_we", fwd_zip[38], 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_allowin", mem_allowin, 1'b1);
        chk("arst_wb_zip", wb_zip, '0);
        chk("arst_fwd", fwd_zip, '0);
        rst    = 1'b0;
        ex_zip = mk_ex(1'b1, 32'h1c00_0500, 32'h0, 1'b1, 5'd8, 32'h0000_0ACE, 1'b0, 1'b0, 5'd0);
        tick();
        ex_zip = '0;
        #1;
        chk("arst_then_accept", wb_zip, {1'b1, 32'h1c00_0500, 32'h0, 1'b1, 5'd8, 32'h0000_0ACE});
        $display("async reset sequence: allowin=%b", mem_allowin);

        // Randomized traffic against the model
        idle_inputs();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        m_valid = 0; m_got = 0; m_orphan = 0;
        m_pc = 0; m_ir = 0; m_alu = 0; m_buf = 0;
        m_we = 0; m_rfm = 0; m_mreq = 0; m_wa = 0; m_lop = 0; m_exc = 0;
        for (int n = 0; n < 400; n++) begin
            data_ok    = ((m_valid && m_mreq && !m_got) || m_orphan) && ($urandom % 3 == 0);
            rdata      = $urandom;
            wb_allowin = ($urandom % 4) != 0;
            wb_flush   = ($urandom % 16) == 0;
            r_lop      = 5'(1 << ($urandom % 5));
            ex_zip     = mk_ex(($urandom % 5) < 3, $urandom, $urandom, 1'($urandom), 5'($urandom),
                               $urandom, 1'b0, 1'($urandom), r_lop);
            ex_zip[6]  = ex_zip[5] & 1'($urandom);
            r_exc      = {18'($urandom), $urandom, $urandom};
            r_exc[81]  = ($urandom % 10) == 0;
            ex_exc     = r_exc;
            #1;
            done    = !m_mreq || m_got || data_ok;
            e_allow = !m_orphan && (!m_valid || (done && wb_allowin));
            e_wd    = m_rfm ? ref_load(m_lop, m_alu[1:0], m_got ? m_buf : rdata) : m_alu;
            chk("rnd_allowin", mem_allowin, e_allow);
            chk("rnd_wb_zip", wb_zip, {m_valid && done && !wb_flush, m_pc, m_ir, m_we, m_wa, e_wd});
            chk("rnd_fwd", fwd_zip, {m_valid && m_we, m_wa, e_wd,
                                     m_valid && ((m_rfm && !done) || m_exc[81])});
            chk("rnd_exc", mem_exc, m_exc);
            if (wb_flush) begin
                m_orphan = (m_orphan || (m_valid && m_mreq && !m_got)) && !data_ok;
                m_valid  = 0;
                m_got    = 0;
            end else if (m_orphan) begin
                if (data_ok) m_orphan = 0;
            end else if (e_allow) begin
                m_got = 0;
                m_valid = ex_zip[109];
                if (ex_zip[109]) begin
                    {m_pc, m_ir, m_we, m_wa, m_alu, m_rfm, m_mreq, m_lop} = ex_zip[108:0];
                    m_exc = ex_exc;
                end
            end else if (m_valid && m_mreq && !m_got && data_ok) begin
                m_got = 1;
                m_buf = rdata;
            end
            tick();
        end
        $display("random phase: 400 cycles applied");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
